latency_credit_wrapper: RTL
===========================

// Module: latency_credit_wrapper
// PURPOSE
// - Valid/ready front end for any fixed-latency, non-stallable datapath (FP64 multiply-add chains etc.).
// - Accepts args, issues them to the datapath, and buffers returning results in an output FIFO.
// - Uses credit-based admission, so downstream backpressure never drops or overwrites a result.
// - Successor to the single-formula wrapper: generalised in widths, datapath latency and buffer depth;
//   adds latency checking and occupancy reporting.
// PARAMETERS
// - AW       64  arg bus width (3*FLEN for a/b/c packing allowed)
// - RW       64  result width (FLEN)
// - LATENCY  8   datapath latency, cycles from dp_vld to dp_res_vld, >=1
// - DEPTH    16  output FIFO entries, >= LATENCY+1 (elaboration $error otherwise)
// PORTS
// - clk         in   1                    clock
// - rst         in   1                    async active-high reset
// - arg_vld     in   1                    arg offered
// - arg_rdy     out  1                    arg accepted when arg_vld&arg_rdy
// - arg         in   AW                   arg payload
// - dp_vld      out  1                    issue strobe to datapath
// - dp_arg      out  AW                   datapath operand (=arg, combinational)
// - dp_res_vld  in   1                    datapath result strobe
// - dp_res      in   RW                   datapath result
// - res_vld     out  1                    result available
// - res_rdy     in   1                    result consumed when res_vld&res_rdy
// - res         out  RW                   result payload, held stable while res_vld&!res_rdy
// - occupancy   out  $clog2(DEPTH+1)      in-flight + buffered count
// - lat_err     out  1                    sticky: dp_res_vld mismatch vs expected
// BEHAVIOUR
// - Interface: one clock clk; reset rst is asynchronous, active-high.
// - Reset values: arg_rdy=1 on first cycle after reset release; res_vld=0, occupancy=0, lat_err=0,
//   FIFO empty, expect shift-register cleared. Reset mid-operation discards all in-flight and buffered data.
// - Admission: arg_rdy = (occupancy < DEPTH); depends only on registered state, never on arg_vld.
//   dp_vld = arg_vld & arg_rdy.
// - occupancy: next = occ + (arg_vld&arg_rdy) - (res_vld&res_rdy); simultaneous accept and pop leaves it
//   unchanged. Full (occ==DEPTH) accepted only when a pop frees an entry the same cycle? NO: arg_rdy is
//   registered-state-only, so no same-cycle reuse.
// - Expect pipe: LATENCY-bit shift register of dp_vld. lat_err is set when tap[LATENCY-1] != dp_res_vld.
// - FIFO push on dp_res_vld (unconditional: credits guarantee space). Pop on res_vld&res_rdy.
// - FIFO pointers wrap modulo DEPTH (non-power-of-2 allowed).
// - Ordering: results leave strictly in acceptance order.
// - Latency arg->res_vld: LATENCY+1 cycles (registered FIFO output).
// - Throughput: 1/cycle sustained when res_rdy=1.
// - With res_rdy=0: accepts exactly DEPTH args, then arg_rdy=0 until first pop.
// - Empty FIFO with res_rdy=1: res_vld stays 0, no underflow.
// CONFIGURATION
// - LCW_BYPASS_EN defined: when FIFO is empty, dp_res_vld is high and the output register is free, the
//   result goes straight to the output register. Latency arg->res_vld = LATENCY+1.
// - LCW_BYPASS_EN undefined: every result passes through FIFO RAM, then the output register.
//   Latency = LATENCY+2. Credit accounting identical in both builds.
// STRUCTURE
// - Shared package flow_pkg: FLEN=64, NE=11, typedef logic [FLEN-1:0] flen_t, function clog2_depth,
//   typedef struct {flen_t a,b,c;} arg3_t.
// - One sub-module flow_fifo (DEPTH, RW): storage, rd/wr pointers, count, empty/full.
// - Top: credit counter, expect pipe, lat_err, bypass mux, output register.
// TESTING
// - Reset then idle: after rst 1->0, arg_rdy=1, res_vld=0, occupancy=0, lat_err=0 with no stimulus.
// - Single transfer, stub datapath res=arg+1, LATENCY=8: arg=5 -> res=6, res_vld exactly LATENCY+1
//   cycles later (LATENCY+2 without LCW_BYPASS_EN).
// - Backpressure, res_rdy=0, arg_vld=1 for 100 cycles: exactly 16 accepts, occupancy=16, arg_rdy=0.
//   Then res_rdy=1 drains results 1..16 in order on consecutive cycles.
// - Back-to-back arg_vld=1 and res_rdy=1, 1000 args: 1000 results, in order, one per cycle in steady
//   state, occupancy never exceeds LATENCY+1.
// - Random res_rdy and random arg gaps (0..22 cycles), stub FP64 a**5+0.3*b-c: scoreboard match, no
//   drop/duplicate, lat_err=0.
// - Fault injection: delay dp_res_vld by 1 cycle -> lat_err=1 next cycle and stays 1.
//   Assert rst mid-stream -> all outputs back to reset values asynchronously.

Source files
------------

// File: rtl/flow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flow_pkg
// Description : Shared FP64 widths, the packed a/b/c argument bundle and a
//               pointer-width helper for the latency credit wrapper family.
// Revision    : 1.0 - initial release
// ============================================================================
package flow_pkg;

    localparam int FLEN = 64;
    localparam int NE   = 11;

    typedef logic [FLEN-1:0] flen_t;

    typedef struct packed {
        flen_t a;
        flen_t b;
        flen_t c;
    } arg3_t;

    // Pointer width for a DEPTH-entry store; never returns less than 1 bit.
    function automatic int clog2_depth(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/flow_fifo.sv
`default_nettype none
// ============================================================================
// Module      : flow_fifo
// Description : DEPTH-entry result store with wrap-modulo-DEPTH pointers
//               (non power-of-two depths allowed) and a combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module flow_fifo
    import flow_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int RW    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [RW-1:0]                i_din,
    input  logic                         i_pop,
    output logic [RW-1:0]                o_dout,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PW = clog2_depth(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] c_last  = PW'(DEPTH-1);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [RW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr_en;
    logic          w_rd_en;

    // A full store may still take a write in the cycle its head is read out.
    assign w_wr_en = i_push && (!o_full || i_pop);
    assign w_rd_en = i_pop && !o_empty;

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_depth);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/latency_credit_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : latency_credit_wrapper
// Description : Credit-admitted valid/ready front end for a fixed-latency,
//               non-stallable datapath. Optional feature macro: LCW_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module latency_credit_wrapper
    import flow_pkg::*;
#(
    parameter int AW      = 64,
    parameter int RW      = 64,
    parameter int LATENCY = 8,
    parameter int DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arg_vld,
    output logic                         arg_rdy,
    input  logic [AW-1:0]                arg,
    output logic                         dp_vld,
    output logic [AW-1:0]                dp_arg,
    input  logic                         dp_res_vld,
    input  logic [RW-1:0]                dp_res,
    output logic                         res_vld,
    input  logic                         res_rdy,
    output logic [RW-1:0]                res,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         lat_err
);

    localparam int OW = $clog2(DEPTH+1);
    localparam logic [OW-1:0] c_depth = OW'(DEPTH);

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("latency_credit_wrapper: LATENCY must be >= 1");
        end
        if (DEPTH < LATENCY + 1) begin : g_bad_depth
            $error("latency_credit_wrapper: DEPTH must be >= LATENCY+1");
        end
    endgenerate

    logic [OW-1:0]      r_occ;
    logic [LATENCY-1:0] r_expect;
    logic               r_lat_err;
    logic               r_res_vld;
    logic [RW-1:0]      r_res;

    logic               w_accept;
    logic               w_pop;
    logic               w_out_free;
    logic               w_bypass;
    logic               w_fifo_push;
    logic               w_fifo_pop;
    logic [RW-1:0]      w_fifo_dout;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [OW-1:0]      w_fifo_count;
    logic               w_tap;

    // Admission looks only at registered occupancy, so a pop never frees a slot same-cycle.
    assign arg_rdy    = (r_occ < c_depth);
    assign w_accept   = arg_vld && arg_rdy;
    assign dp_vld     = w_accept;
    assign dp_arg     = arg;
    assign w_pop      = r_res_vld && res_rdy;
    assign w_out_free = !r_res_vld || res_rdy;

`ifdef LCW_BYPASS_EN
    assign w_bypass = dp_res_vld && w_fifo_empty && w_out_free;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_fifo_push = dp_res_vld && !w_bypass;
    assign w_fifo_pop  = w_out_free && !w_fifo_empty;

    flow_fifo #(
        .DEPTH (DEPTH),
        .RW    (RW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_din   (dp_res),
        .i_pop   (w_fifo_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Bit k of the expect pipe marks an issue made k+1 cycles ago.
    generate
        if (LATENCY == 1) begin : g_expect_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_expect <= '0;
                end else begin
                    r_expect <= w_accept;
                end
            end
        end else begin : g_expect_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_expect <= '0;
                end else begin
                    r_expect <= {r_expect[LATENCY-2:0], w_accept};
                end
            end
        end
    endgenerate

    assign w_tap = r_expect[LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat_err <= 1'b0;
        end else if (w_tap != dp_res_vld) begin
            r_lat_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_vld <= 1'b0;
            r_res     <= '0;
        end else if (w_fifo_pop) begin
            r_res_vld <= 1'b1;
            r_res     <= w_fifo_dout;
        end else if (w_bypass) begin
            r_res_vld <= 1'b1;
            r_res     <= dp_res;
        end else if (res_rdy) begin
            r_res_vld <= 1'b0;
        end
    end

    assign res_vld   = r_res_vld;
    assign res       = r_res;
    assign occupancy = r_occ;
    assign lat_err   = r_lat_err;

    // Credits bound buffered results by occupancy, so the store can never overflow.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (w_fifo_count <= r_occ) && !(w_fifo_push && w_fifo_full && !w_fifo_pop));

endmodule
`default_nettype wire
